uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Frame format is set at elaboration time: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits. Adds parity-error and framing-error reporting, a busy flag and post-error line recovery. Sits between the board RX pin and the command/packet parser, in a single clock domain.

---
 rtl/uart_rx_cfg.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with parity/framing error flags, busy flag and
// post-error line recovery. Single clock domain.
//
// Ports:
//   i_Clock      system clock
//   i_Reset      synchronous, active-high reset
//   i_Rx_Serial  asynchronous serial line, idle high
//   o_Rx_DV      one-cycle pulse: frame complete, qualifies byte and flags
//   o_Rx_Byte    received data, LSB = first data bit
//   o_Parity_Err parity mismatch in the last frame (0 when PARITY = 0)
//   o_Frame_Err  a stop-bit sample was 0 in the last frame
//   o_Busy       high whenever the receiver is not idle
//   o_Break      one-cycle break pulse (only with UART_RX_BREAK_DET_EN)
//
// Build option: define UART_RX_BREAK_DET_EN to report an all-zero frame as a
// break pulse instead of a data byte. Undefined, o_Break is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | timing to the middle of the start bit, glitch rejection
// DATA      | sampling DATA_BITS data bits at mid-bit
// PARITY    | sampling the parity bit
// STOP      | sampling STOP_BITS stop bits
// CLEANUP   | one cycle with o_Rx_DV (or o_Break) asserted
// WAIT_HIGH | line still low after a frame, wait for it to return high

module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 105,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = 21
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic                 o_Break
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 1);

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 rx_dv_q, rx_dv_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tick;
    logic                 par_exp;
    logic                 frm_last;
`ifdef UART_RX_BREAK_DET_EN
    logic                 all_zero_q, all_zero_d;
    logic                 break_q, break_d;
    logic                 zero_last;
`endif

    assign tick    = (cnt_q == CNT_BIT);
    // shift_q holds all data bits once the parity bit is being sampled
    assign par_exp = (^shift_q) ^ ODD_PAR;

    always_comb begin
        state_d      = state_q;
        rx_meta_d    = i_Rx_Serial;
        rx_s_d       = rx_meta_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        rx_dv_d      = 1'b0;
        rx_byte_d    = rx_byte_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        frm_last     = frm_err_q | ~rx_s_q;
`ifdef UART_RX_BREAK_DET_EN
        all_zero_d   = all_zero_q;
        break_d      = 1'b0;
        zero_last    = all_zero_q & ~rx_s_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                par_err_d = 1'b0;
                frm_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                all_zero_d = 1'b1;
`endif
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // a line that is high again at mid start bit was a glitch
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    all_zero_d = zero_last;
`endif
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    if (rx_s_q != par_exp) begin
                        par_err_d = 1'b1;
                    end
`ifdef UART_RX_BREAK_DET_EN
                    all_zero_d = zero_last;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (tick) begin
                    cnt_d     = '0;
                    frm_err_d = frm_last;
`ifdef UART_RX_BREAK_DET_EN
                    all_zero_d = zero_last;
`endif
                    if (bit_idx_q == LAST_STOP) begin
                        // leave at mid stop bit so back-to-back frames fit
                        bit_idx_d = '0;
                        state_d   = S_CLEANUP;
`ifdef UART_RX_BREAK_DET_EN
                        if (zero_last) begin
                            break_d = 1'b1;
                        end else begin
                            rx_dv_d      = 1'b1;
                            rx_byte_d    = shift_q;
                            parity_err_d = par_err_q;
                            frame_err_d  = frm_last;
                        end
`else
                        rx_dv_d      = 1'b1;
                        rx_byte_d    = shift_q;
                        parity_err_d = par_err_q;
                        frame_err_d  = frm_last;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_CLEANUP: begin
                state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
`ifdef UART_RX_BREAK_DET_EN
                if (break_q) begin
                    state_d = S_WAIT_HIGH;
                end
`endif
            end

            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            rx_dv_q      <= 1'b0;
            rx_byte_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q   <= 1'b1;
            break_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            rx_dv_q      <= rx_dv_d;
            rx_byte_q    <= rx_byte_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q   <= all_zero_d;
            break_q      <= break_d;
`endif
        end
    end

    assign o_Rx_DV      = rx_dv_q;
    assign o_Rx_Byte    = rx_byte_q;
    assign o_Parity_Err = parity_err_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Busy       = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign o_Break      = break_q;
`else
    assign o_Break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: one 8N1 receiver (line a) and one 7E2 receiver
// (line b), both at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b;
    logic       dv_a, perr_a, ferr_a, busy_a, brk_a;
    logic [7:0] byte_a;
    logic       dv_b, perr_b, ferr_b, busy_b, brk_b;
    logic [6:0] byte_b;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(8)) u_a (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a),
        .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_Busy(busy_a), .o_Break(brk_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CNT_W(8)) u_b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b),
        .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_Busy(busy_b), .o_Break(brk_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitors
    int         dv_n_a = 0, brk_n_a = 0, dv_n_b = 0, brk_n_b = 0;
    int         dv_cyc_a = 0;
    logic [7:0] cap_byte_a = '0;
    logic       cap_perr_a = 1'b0, cap_ferr_a = 1'b0;
    logic [6:0] cap_byte_b = '0;
    logic       cap_perr_b = 1'b0, cap_ferr_b = 1'b0;

    always @(negedge clk) begin
        if (dv_a) begin
            dv_n_a++;
            dv_cyc_a   = cyc;
            cap_byte_a = byte_a;
            cap_perr_a = perr_a;
            cap_ferr_a = ferr_a;
        end
        if (brk_a) brk_n_a++;
        if (dv_b) begin
            dv_n_b++;
            cap_byte_b = byte_b;
            cap_perr_b = perr_b;
            cap_ferr_b = ferr_b;
        end
        if (brk_b) brk_n_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bits[0] goes out first; line returns high afterwards
    task automatic send(input int ln, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (ln == 0) rx_a = bits[i]; else rx_b = bits[i];
            wait_clks(CPB);
        end
        if (ln == 0) rx_a = 1'b1; else rx_b = 1'b1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        send(0, {6'b0, stop, d, 1'b0}, 10);
    endtask

    task automatic send_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
        send(1, {5'b0, s2, s1, p, d, 1'b0}, 11);
    endtask

    // reference: what one 8N1 frame should produce
    task automatic frame_a(input string tag, input logic [7:0] d, input logic stop);
        int  dv0, br0;
        logic is_brk;
        dv0 = dv_n_a;
        br0 = brk_n_a;
        is_brk = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        is_brk = (d == 8'h00) && !stop;
`endif
        send_a(d, stop);
        wait_clks(20);
        if (is_brk) begin
            check({tag, "_brk"}, 32'(brk_n_a - br0), 32'd1);
            check({tag, "_dv"}, 32'(dv_n_a - dv0), 32'd0);
        end else begin
            check({tag, "_dv"}, 32'(dv_n_a - dv0), 32'd1);
            check({tag, "_byte"}, 32'(cap_byte_a), 32'(d));
            check({tag, "_perr"}, 32'(cap_perr_a), 32'd0);
            check({tag, "_ferr"}, 32'(cap_ferr_a), 32'(!stop));
        end
    endtask

    // reference: one 7E2 frame; parity error when the sent bit differs from
    // the even parity of the data, frame error when any stop bit is low
    task automatic frame_b(input string tag, input logic [6:0] d, input logic p,
                           input logic s1, input logic s2);
        int   dv0, br0, ones;
        logic is_brk, exp_perr;
        dv0 = dv_n_b;
        br0 = brk_n_b;
        ones = 0;
        for (int i = 0; i < 7; i++) ones += int'(d[i]);
        exp_perr = (p != ((ones % 2) == 1));
        is_brk = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        is_brk = (d == 7'h00) && !p && !s1 && !s2;
`endif
        send_b(d, p, s1, s2);
        wait_clks(20);
        if (is_brk) begin
            check({tag, "_brk"}, 32'(brk_n_b - br0), 32'd1);
            check({tag, "_dv"}, 32'(dv_n_b - dv0), 32'd0);
        end else begin
            check({tag, "_dv"}, 32'(dv_n_b - dv0), 32'd1);
            check({tag, "_byte"}, 32'(cap_byte_b), 32'(d));
            check({tag, "_perr"}, 32'(cap_perr_b), 32'(exp_perr));
            check({tag, "_ferr"}, 32'(cap_ferr_b), 32'(!s1 || !s2));
        end
    endtask

    typedef struct {
        logic [6:0] data;
        logic       pflip;
        logic       s1;
        logic       s2;
        logic [6:0] exp_byte;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   dv0, br0, start_cyc;
        logic p;
        logic [7:0] rd;
        logic [6:0] rb;

        vecs[0] = '{7'h03, 1'b0, 1'b1, 1'b1, 7'h03, 1'b0, 1'b0};
        vecs[1] = '{7'h03, 1'b1, 1'b1, 1'b1, 7'h03, 1'b1, 1'b0};
        vecs[2] = '{7'h7F, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
        vecs[3] = '{7'h00, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0};
        vecs[4] = '{7'h55, 1'b0, 1'b0, 1'b1, 7'h55, 1'b0, 1'b1};
        vecs[5] = '{7'h2A, 1'b1, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b1};
        vecs[6] = '{7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1};

        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(1);

        check("rst_dv", 32'(dv_a), 32'd0);
        check("rst_byte", 32'(byte_a), 32'd0);
        check("rst_perr", 32'(perr_a), 32'd0);
        check("rst_ferr", 32'(ferr_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_brk", 32'(brk_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        wait_clks(5);

        // 8N1 0xA5 with latency and busy checks
        dv0 = dv_n_a;
        start_cyc = cyc;
        send_a(8'hA5, 1'b1);
        wait_clks(20);
        check("a5_dv", 32'(dv_n_a - dv0), 32'd1);
        check("a5_byte", 32'(cap_byte_a), 32'hA5);
        check("a5_perr", 32'(cap_perr_a), 32'd0);
        check("a5_ferr", 32'(cap_ferr_a), 32'd0);
        check("a5_lat_ok", 32'((dv_cyc_a - start_cyc) >= 153 && (dv_cyc_a - start_cyc) <= 157), 32'd1);
        check("a5_busy", 32'(busy_a), 32'd0);

        // reset in the middle of data bits of 0xFF
        dv0 = dv_n_a;
        send(0, 16'h0006, 3);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("mrst_dv", 32'(dv_a), 32'd0);
        check("mrst_byte", 32'(byte_a), 32'd0);
        check("mrst_perr", 32'(perr_a), 32'd0);
        check("mrst_ferr", 32'(ferr_a), 32'd0);
        check("mrst_busy", 32'(busy_a), 32'd0);
        wait_clks(7 * CPB + 20);
        check("mrst_nodv", 32'(dv_n_a - dv0), 32'd0);
        frame_a("after_rst", 8'h81, 1'b1);

        // short glitch is rejected
        dv0 = dv_n_a;
        rx_a = 1'b0;
        wait_clks(4);
        check("glitch_busy_hi", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        wait_clks(8);
        check("glitch_busy_lo", 32'(busy_a), 32'd0);
        wait_clks(12 * CPB);
        check("glitch_nodv", 32'(dv_n_a - dv0), 32'd0);

        // 7E2 vector table
        for (int i = 0; i < 7; i++) begin
            dv0 = dv_n_b;
            p = (^vecs[i].data) ^ vecs[i].pflip;
            send_b(vecs[i].data, p, vecs[i].s1, vecs[i].s2);
            wait_clks(20);
            check($sformatf("vec%0d_dv", i), 32'(dv_n_b - dv0), 32'd1);
            check($sformatf("vec%0d_byte", i), 32'(cap_byte_b), 32'(vecs[i].exp_byte));
            check($sformatf("vec%0d_perr", i), 32'(cap_perr_b), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), 32'(cap_ferr_b), 32'(vecs[i].exp_ferr));
        end

        // second stop low, line held low: one DV then wait for high
        dv0 = dv_n_b;
        send_b(7'h03, 1'b0, 1'b1, 1'b0);
        rx_b = 1'b0;
        wait_clks(3 * CPB);
        check("hold_dv", 32'(dv_n_b - dv0), 32'd1);
        check("hold_ferr", 32'(cap_ferr_b), 32'd1);
        check("hold_perr", 32'(cap_perr_b), 32'd0);
        check("hold_busy", 32'(busy_b), 32'd1);
        rx_b = 1'b1;
        wait_clks(20);
        check("hold_nodv", 32'(dv_n_b - dv0), 32'd1);
        check("hold_idle", 32'(busy_b), 32'd0);
        frame_b("after_hold", 7'h5A, 1'b0, 1'b1, 1'b1);

        // line low for 12 bit times on 8N1
        dv0 = dv_n_a;
        br0 = brk_n_a;
        rx_a = 1'b0;
        wait_clks(12 * CPB);
`ifdef UART_RX_BREAK_DET_EN
        check("brk_pulse", 32'(brk_n_a - br0), 32'd1);
        check("brk_nodv", 32'(dv_n_a - dv0), 32'd0);
`else
        check("brk_dv", 32'(dv_n_a - dv0), 32'd1);
        check("brk_byte", 32'(cap_byte_a), 32'd0);
        check("brk_ferr", 32'(cap_ferr_a), 32'd1);
        check("brk_nopulse", 32'(brk_n_a - br0), 32'd0);
`endif
        check("brk_busy", 32'(busy_a), 32'd1);
        dv0 = dv_n_a;
        wait_clks(4 * CPB);
        check("brk_still_low", 32'(dv_n_a - dv0), 32'd0);
        rx_a = 1'b1;
        wait_clks(20);
        check("brk_released", 32'(dv_n_a - dv0), 32'd0);
        check("brk_idle", 32'(busy_a), 32'd0);

        // random frames against the reference tasks
        for (int i = 0; i < 16; i++) begin
            rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            frame_a($sformatf("rnd_a%0d", i), rd, $urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
            frame_b($sformatf("rnd_b%0d", i), rb, 1'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
